q2_seqgen01: RTL
================

# q2_seqgen01

Serial pattern transmitter that drives the bit stream consumed by the "01" sequence detectors in the Mealy/Moore exercise benches. A parallel pattern word is loaded through a ready/load handshake and emitted MSB-first, one bit per clock, on `x_out`. The block also counts the "01" pairs it has emitted, which gives benches a reference count to check against detector `y_out` pulses.

## Interface
- `WIDTH`, default 10: pattern word length in bits.
- `LEN_W`, default 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `MCNT_W`, default 4: width of `match_cnt`.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load`  input  1  start request; sampled only while `ready`=1.
- `pattern`  input  WIDTH  bits to send; bit WIDTH-1 is sent first.
- `len`  input  LEN_W  number of bits to send; 0 or values > WIDTH mean WIDTH.
- `ready`  output  1  idle; a new load is accepted.
- `x_out`  output  1  serial bit, qualified by `x_valid`.
- `x_valid`  output  1  `x_out` carries a pattern bit this cycle.
- `done`  output  1  one-cycle pulse after the last bit.
- `match_cnt`  output  MCNT_W  number of "01" pairs emitted so far in the current or last transfer; saturates.

## Operation
- All outputs are registered. Reset values: `ready`=1, `x_out`=0, `x_valid`=0, `done`=0, `match_cnt`=0. State is IDLE, the shift register is 0 and `remaining`=0.
- States:
  - IDLE: `ready`=1. On `load`=1, capture `pattern` into the shift register, set `remaining` = effective len, clear `match_cnt` and the previous-bit flag, then go to SHIFT.
  - SHIFT: `x_valid`=1 and `x_out` = current MSB. At each edge, shift left by one (zero fill) and decrement `remaining`. When `remaining`=1 at the edge, go to DONE.
  - DONE: `done`=1, `x_valid`=0, `x_out`=0, `ready`=0. Go to IDLE on the next edge.
- `match_cnt` increments at the edge that presents a 1 on `x_out` when the previously presented bit of the same transfer was 0. The first bit of a transfer never counts. `match_cnt` saturates at 2^MCNT_W-1 and holds its value through DONE and IDLE until the next accepted load.
- `load` while `ready`=0 is ignored. `pattern` and `len` are don't-care except at the accepting edge.
- Reset asserted mid-transfer forces reset values immediately, without waiting for a clock edge. The transfer is abandoned and no `done` pulse is produced.

## Timing
- Load accepted at edge k:
  - `ready` falls and `x_valid` rises after edge k.
  - Bit i (i=0..L-1, MSB first) is on `x_out` from edge k+i to edge k+i+1.
  - `done` is high from edge k+L to edge k+L+1.
  - `ready` returns high after edge k+L+1.
- Transfer occupancy is L+1 cycles. Back-to-back loads therefore have a minimum spacing of L+2 edges.
- `x_valid` is high for exactly L consecutive cycles per transfer.
- `match_cnt` is final when `done` is high.

## Test plan
- Basic transfer: reset, then `pattern`=10'b0100110111, `len`=10, `load` pulse. Required: `x_out` = 0,1,0,0,1,1,0,1,1,1 over 10 `x_valid` cycles; `done` one cycle later; `match_cnt`=3.
- Length handling:
  - `len`=0 with the same pattern sends all 10 bits, `match_cnt`=3.
  - `len`=3 sends 0,1,0, `match_cnt`=1, and `done` is asserted 3 edges after load.
  - `len`=15 (greater than WIDTH) behaves as `len`=10.
- Busy load: during the SHIFT state of the basic transfer, pulse `load` with `pattern`=10'h3FF. Required: the stream is unchanged, and the new pattern is accepted only when `load` is reapplied after `ready`=1.
- Saturation: with `MCNT_W`=2, send `pattern`=10'b0101010101 (5 pairs). Required: `match_cnt` reaches 3 and holds at 3, with all 10 bits emitted correctly.
- Reset mid-transfer: drop `rst` after bit 4 of the basic transfer. Required: outputs go to reset values immediately with no `done` pulse. After `rst` is released, a fresh load of 10'b0100110111 produces the full correct stream.
- Loopback: connect `x_out` to the q2 Mealy "01" detector input, enabled by `x_valid`, and send 10'b0100110111. Required: the bench's count of detector detections equals `match_cnt`=3.

Source files
------------

// File: rtl/q2_seqgen01_if.sv
// q2_seqgen01 bus: load handshake plus serial stream outputs.
// Master drives load/pattern/len; slave returns the stream and status.
interface q2_seqgen01_if #(
    parameter int WIDTH  = 10,
    parameter int LEN_W  = 4,
    parameter int MCNT_W = 4
);
    logic              load;
    logic [WIDTH-1:0]  pattern;
    logic [LEN_W-1:0]  len;
    logic              ready;
    logic              x_out;
    logic              x_valid;
    logic              done;
    logic [MCNT_W-1:0] match_cnt;

    modport master (
        output load, pattern, len,
        input  ready, x_out, x_valid, done, match_cnt
    );

    modport slave (
        input  load, pattern, len,
        output ready, x_out, x_valid, done, match_cnt
    );
endinterface

// File: rtl/q2_seqgen01.sv
// Serial "01" pattern transmitter: loads a word, shifts it out MSB-first,
// and counts the "01" pairs it emits (saturating).
module q2_seqgen01 #(
    parameter int WIDTH  = 10,
    parameter int LEN_W  = 4,
    parameter int MCNT_W = 4
) (
    input logic           clk,
    input logic           rst,
    q2_seqgen01_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [LEN_W-1:0]  WLEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0]  ONE  = LEN_W'(1);
    localparam logic [MCNT_W-1:0] CMAX = '1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d, sr_shl;
    logic [LEN_W-1:0]  rem_q, rem_d, eff_len;
    logic [MCNT_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              xo_q, xo_d;
    logic              xv_q, xv_d;
    logic              done_q, done_d;

    // Zero or oversized lengths fall back to the full word.
    always_comb begin
        eff_len = bus.len;
        if (bus.len == '0 || bus.len > WLEN)
            eff_len = WLEN;
    end

    assign sr_shl = sr_q << 1;

    // Next-state and next-output decode; the presented bit doubles as
    // the previous-bit flag for pair counting.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        xo_d    = 1'b0;
        xv_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.load) begin
                    state_d = SHIFT;
                    sr_d    = bus.pattern;
                    rem_d   = eff_len;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    xv_d    = 1'b1;
                    xo_d    = bus.pattern[WIDTH-1];
                end
            end
            SHIFT: begin
                sr_d  = sr_shl;
                rem_d = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    xv_d = 1'b1;
                    xo_d = sr_shl[WIDTH-1];
                    if (!xo_q && sr_shl[WIDTH-1] && cnt_q != CMAX)
                        cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transfer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            xo_q    <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            xo_q    <= xo_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.x_out     = xo_q;
    assign bus.x_valid   = xv_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = cnt_q;
endmodule
